// File: rtl/greycode_pkg.sv
// greycode_pkg: shared definitions for the Gray-code blocks.
//   state_e       - lock state of the decoder (ST_UNLOCKED / ST_LOCKED)
//   DEFAULT_WIDTH - default count width
//   DEFAULT_ERR_W - default error counter width
//   grey2bin()    - Gray-to-binary conversion for counts up to 32 bits
//                   (upper bits of the argument must be zero)
package greycode_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_ERR_W = 8;

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } state_e;

    // Binary bit i is the parity of all Gray bits at position i and above.
    function automatic logic [31:0] grey2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/greycode_decoder_grey2bin.sv
// grey2bin: purely combinational reflected-binary Gray to binary decoder.
//   g_i   [WIDTH-1:0] - Gray-coded input
//   bin_o [WIDTH-1:0] - binary equivalent
module grey2bin
    import greycode_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] g_i,
    output logic [WIDTH-1:0] bin_o
);

    logic [WIDTH-1:0] b;

    // MSB passes through; each lower bit folds in the decoded bit above it.
    always_comb begin
        b            = '0;
        b[WIDTH-1]   = g_i[WIDTH-1];
        for (int unsigned k = 1; k < WIDTH; k++) begin
            b[WIDTH-1-k] = b[WIDTH-k] ^ g_i[WIDTH-1-k];
        end
    end

    assign bin_o = b;

endmodule

// File: rtl/greycode_decoder.sv
// greycode_decoder: samples a Gray-coded count bus, converts each accepted
// sample to binary and classifies it against the previous sample.
//   clk, rst   - clock, asynchronous active-high reset
//   resync     - synchronous: drop lock, clear error count, discard samples
//   in_valid   - grey_in carries a sample this cycle
//   grey_in    - Gray-coded count
//   out_valid  - one-cycle pulse per decoded sample (2 cycles after input)
//   bin_out    - binary value of the sample
//   step_ok    - sample = previous + 1 (mod 2^WIDTH)
//   hold       - sample = previous
//   wrap       - all-ones to zero transition (step_ok also set)
//   step_err   - any other transition
//   locked     - a reference sample exists
//   err_count  - saturating count of step_err events
module greycode_decoder
    import greycode_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned ERR_W = DEFAULT_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resync,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] grey_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic             step_ok,
    output logic             hold,
    output logic             wrap,
    output logic             step_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    // Stage 1 registers
    logic [WIDTH-1:0] g_q;
    logic             v_q;

    // Stage 2 / FSM registers
    state_e           state_q;
    logic [WIDTH-1:0] prev_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] bin_q;
    logic             step_ok_q;
    logic             hold_q;
    logic             wrap_q;
    logic             step_err_q;
    logic [ERR_W-1:0] err_q;

    // Classifier
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] prev_inc;
    logic             is_step;
    logic             is_hold;
    logic             is_wrap;
    logic             is_err;
    logic [ERR_W-1:0] err_d;

    grey2bin #(
        .WIDTH(WIDTH)
    ) u_grey2bin (
        .g_i  (g_q),
        .bin_o(bin_d)
    );

    assign prev_inc = prev_q + 1'b1;
    assign is_step  = (bin_d == prev_inc);
    assign is_hold  = (bin_d == prev_q);
    assign is_wrap  = is_step && (prev_q == '1);
    assign is_err   = !is_step && !is_hold;
    assign err_d    = (err_q == '1) ? err_q : err_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q <= '0;
            v_q <= 1'b0;
        end else if (resync) begin
            v_q <= 1'b0;
        end else begin
            g_q <= grey_in;
            v_q <= in_valid;
        end
    end

    // resync also suppresses the sample already in stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            prev_q      <= '0;
            out_valid_q <= 1'b0;
            bin_q       <= '0;
            step_ok_q   <= 1'b0;
            hold_q      <= 1'b0;
            wrap_q      <= 1'b0;
            step_err_q  <= 1'b0;
            err_q       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            step_ok_q   <= 1'b0;
            hold_q      <= 1'b0;
            wrap_q      <= 1'b0;
            step_err_q  <= 1'b0;
            if (resync) begin
                state_q <= ST_UNLOCKED;
                err_q   <= '0;
            end else if (v_q) begin
                out_valid_q <= 1'b1;
                bin_q       <= bin_d;
                prev_q      <= bin_d;
                case (state_q)
                    ST_UNLOCKED: begin
                        state_q <= ST_LOCKED;
                    end
                    ST_LOCKED: begin
                        step_ok_q  <= is_step;
                        hold_q     <= is_hold;
                        wrap_q     <= is_wrap;
                        step_err_q <= is_err;
                        if (is_err) begin
                            err_q <= err_d;
                        end
                    end
                    default: begin
                        state_q <= ST_UNLOCKED;
                    end
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;
    assign step_ok   = step_ok_q;
    assign hold      = hold_q;
    assign wrap      = wrap_q;
    assign step_err  = step_err_q;
    assign locked    = (state_q == ST_LOCKED);
    assign err_count = err_q;

endmodule

// File: tb/tb_greycode_decoder.sv
// Self-checking bench for greycode_decoder (WIDTH=8, ERR_W=8).
module tb_greycode_decoder;

    logic       clk;
    logic       rst;
    logic       resync;
    logic       in_valid;
    logic [7:0] grey_in;
    logic       out_valid;
    logic [7:0] bin_out;
    logic       step_ok;
    logic       hold;
    logic       wrap;
    logic       step_err;
    logic       locked;
    logic [7:0] err_count;

    greycode_decoder #(
        .WIDTH(8),
        .ERR_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .resync   (resync),
        .in_valid (in_valid),
        .grey_in  (grey_in),
        .out_valid(out_valid),
        .bin_out  (bin_out),
        .step_ok  (step_ok),
        .hold     (hold),
        .wrap     (wrap),
        .step_err (step_err),
        .locked   (locked),
        .err_count(err_count)
    );

    typedef struct {
        logic [7:0] bin;
        logic [4:0] flags;   // {step_ok, hold, wrap, step_err, locked}
        logic [7:0] ec;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         passed = 0;
    int         cyc = 0;

    // Reference model state
    logic       m_lock;
    logic [7:0] m_prev;
    logic [7:0] m_ec;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: pops one expectation per out_valid pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_out_valid: got bin_out=%h at cycle %0d, required no output", bin_out, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bin_out !== e.bin || {step_ok, hold, wrap, step_err, locked} !== e.flags
                        || err_count !== e.ec || cyc != e.due) begin
                        $display("FAIL sample: got bin=%h flags=%b ec=%0d cyc=%0d, required bin=%h flags=%b ec=%0d cyc=%0d",
                                 bin_out, {step_ok, hold, wrap, step_err, locked}, err_count, cyc,
                                 e.bin, e.flags, e.ec, e.due);
                    end else begin
                        passed++;
                    end
                end
            end else begin
                total++;
                if ({step_ok, hold, wrap, step_err} !== 4'b0000) begin
                    $display("FAIL idle_flags: got %b, required 0000", {step_ok, hold, wrap, step_err});
                end else begin
                    passed++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Inverse by search: the n whose Gray code n^(n>>1) equals g.
    function automatic logic [7:0] model_decode(input logic [7:0] g);
        logic [7:0] r;
        r = '0;
        for (int n = 0; n < 256; n++) begin
            logic [7:0] nn;
            nn = 8'(n);
            if ((nn ^ (nn >> 1)) == g) r = nn;
        end
        return r;
    endfunction

    task automatic model_clear(input logic clr_ec);
        m_lock = 1'b0;
        if (clr_ec) begin
            m_ec   = '0;
            m_prev = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample and push its expected result.
    task automatic send(input logic [7:0] g);
        exp_t       e;
        logic [7:0] b;
        logic [7:0] nxt;
        logic       ok, hd, wr, er;
        b   = model_decode(g);
        nxt = m_prev + 8'd1;
        ok  = 1'b0; hd = 1'b0; wr = 1'b0; er = 1'b0;
        if (m_lock) begin
            ok = (b == nxt);
            hd = (b == m_prev);
            wr = ok && (m_prev == 8'hFF);
            er = !ok && !hd;
            if (er && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
        end
        m_lock  = 1'b1;
        m_prev  = b;
        e.bin   = b;
        e.flags = {ok, hd, wr, er, 1'b1};
        e.ec    = m_ec;
        e.due   = cyc + 2;
        q.push_back(e);
        in_valid = 1'b1;
        grey_in  = g;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending outputs, required 0", q.size());
            q.delete();
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        resync   = 1'b0;
        in_valid = 1'b0;
        grey_in  = '0;
        #1;
        total++;
        if ({out_valid, bin_out, step_ok, hold, wrap, step_err, locked, err_count} !== '0) begin
            $display("FAIL reset_outputs: got ov=%b bin=%h flags=%b lock=%b ec=%0d, required all 0",
                     out_valid, bin_out, {step_ok, hold, wrap, step_err}, locked, err_count);
        end else begin
            passed++;
        end
        q.delete();
        model_clear(1'b1);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sequence();
        send(8'h00);
        send(8'h01);
        send(8'h03);
        send(8'h02);
        send(8'h06);
        drain();
    endtask

    task automatic test_wrap();
        send(8'h81);
        send(8'h80);
        send(8'h00);
        drain();
        send(8'h01);
        tick();
        send(8'h03);
        drain();
    endtask

    task automatic test_hold_err();
        send(8'h02);
        send(8'h02);
        send(8'h05);
        send(8'h04);
        drain();
        total++;
        if (err_count !== 8'd1) begin
            $display("FAIL hold_err_count: got %0d, required 1", err_count);
        end else begin
            passed++;
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            send((i % 2 == 0) ? 8'h00 : 8'h03);
        end
        drain();
        total++;
        if (err_count !== 8'hFF) begin
            $display("FAIL err_saturate: got %0d, required 255", err_count);
        end else begin
            passed++;
        end
    endtask

    task automatic test_resync();
        // Same-cycle sample is discarded.
        resync   = 1'b1;
        in_valid = 1'b1;
        grey_in  = 8'h07;
        tick();
        resync   = 1'b0;
        in_valid = 1'b0;
        model_clear(1'b1);
        total++;
        if (out_valid !== 1'b0 || locked !== 1'b0 || err_count !== 8'd0) begin
            $display("FAIL resync_state: got ov=%b lock=%b ec=%0d, required 0 0 0", out_valid, locked, err_count);
        end else begin
            passed++;
        end
        tick();
        tick();
        send(8'h06);
        drain();
        // Sample already in stage 1 when resync arrives is dropped too.
        in_valid = 1'b1;
        grey_in  = 8'h07;
        tick();
        in_valid = 1'b0;
        resync   = 1'b1;
        tick();
        resync   = 1'b0;
        model_clear(1'b1);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b0 || locked !== 1'b0) begin
                $display("FAIL resync_drop: got ov=%b lock=%b, required 0 0", out_valid, locked);
            end else begin
                passed++;
            end
            tick();
        end
        send(8'h05);
        send(8'h04);
        drain();
    endtask

    task automatic test_midstream_reset();
        send(8'h10);
        send(8'h30);
        in_valid = 1'b1;
        grey_in  = 8'h31;
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, bin_out, step_ok, hold, wrap, step_err, locked, err_count} !== '0) begin
            $display("FAIL midstream_reset: got ov=%b bin=%h lock=%b ec=%0d, required all 0",
                     out_valid, bin_out, locked, err_count);
        end else begin
            passed++;
        end
        q.delete();
        model_clear(1'b1);
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                $display("FAIL post_reset_idle: got out_valid=%b, required 0", out_valid);
            end else begin
                passed++;
            end
        end
        send(8'h01);
        send(8'h03);
        drain();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_wrap();
        test_reset();
        test_hold_err();
        test_saturate();
        test_resync();
        test_midstream_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/greycode_decoder.md
# greycode_decoder

Receive-side counterpart of the Gray-code counter. It samples a Gray-coded count bus and converts each accepted sample to binary. It then checks that consecutive samples follow the legal +1 (or hold) sequence and reports steps, wrap-around and sequence errors. It sits at the consumer end of any Gray-coded count link, for example a counter observed across a boundary, and feeds binary counts downstream.

## Interface
- `WIDTH`, 8 — count width in bits, must be ≥2.
- `ERR_W`, 8 — width of the saturating error counter.

- `clk` in 1 — single clock; all logic is rising-edge.
- `rst` in 1 — asynchronous, active-high reset.
- `resync` in 1 — synchronous; drops lock and clears error state.
- `in_valid` in 1 — `grey_in` is valid this cycle; there is no backpressure.
- `grey_in` in WIDTH — reflected-binary Gray count.
- `out_valid` out 1 — result outputs are valid; one-cycle pulse per sample.
- `bin_out` out WIDTH — binary value of the sample.
- `step_ok` out 1 — sample = previous + 1 (mod 2^WIDTH).
- `hold` out 1 — sample = previous.
- `wrap` out 1 — previous was all-ones and sample is 0; `step_ok` is also 1.
- `step_err` out 1 — any other transition.
- `locked` out 1 — a reference sample exists.
- `err_count` out ERR_W — number of `step_err` events, saturating.

## Operation
- Decode: `bin[WIDTH-1] = g[WIDTH-1]`; `bin[i] = bin[i+1] ^ g[i]`.
- Stage 1: register `grey_in` and `in_valid` into `g_q` and `v_q`.
- Stage 2: decode `g_q`, classify the result against `prev_bin`, then register all result outputs.
- State machine has two states, UNLOCKED and LOCKED.
  - UNLOCKED with `v_q`=1: emit the sample with `step_ok`/`hold`/`wrap`/`step_err` = 0, load `prev_bin`, go to LOCKED.
  - LOCKED with `v_q`=1: classify the sample, update `prev_bin` to the sample, stay in LOCKED.
  - A `step_err` does not drop lock; the erroneous sample becomes the new reference.
- Exactly one of `step_ok`/`hold`/`step_err` is 1 on each `out_valid` cycle while locked. All flags are 0 when `out_valid`=0.
- `err_count` increments on each `step_err` and saturates at 2^ERR_W−1.
- `resync`=1 takes priority over everything:
  - state goes to UNLOCKED, `err_count` to 0, `v_q` to 0.
  - `out_valid` is 0 the next cycle.
  - The same-cycle `in_valid` sample is discarded.
- Reset values: state UNLOCKED, `g_q`=0, `v_q`=0, `prev_bin`=0. All outputs are 0, including `locked`, `bin_out` and `err_count`.

## Timing
- Latency is 2 cycles: a sample presented with `in_valid` at edge N appears with `out_valid` at edge N+2.
- Throughput is one sample per cycle. Gaps in `in_valid` are allowed and do not affect the comparison.
- `locked` rises in the same cycle as the first post-reset or post-resync `out_valid`.
- If `rst` asserts mid-stream, in-flight samples are lost and outputs clear immediately (asynchronous).
- If `resync` asserts while a sample is in stage 1, that sample is dropped and no `out_valid` is produced for it.

## Structure
- Package `greycode_pkg` holds:
  - the state enum (`ST_UNLOCKED`, `ST_LOCKED`);
  - the default `WIDTH` and `ERR_W` constants;
  - a `grey2bin` function shared with other Gray-code blocks.
- One sub-module, `grey2bin`: purely combinational, parameterised by `WIDTH`, instantiated in stage 2.
- All other logic stays in `greycode_decoder`: the stage registers, the classifier, the FSM and the error counter.

## Test plan
- Reset, then `grey_in` = 0x00, 0x01, 0x03, 0x02, 0x06 on consecutive cycles → `out_valid` from edge N+2 with `bin_out` = 0, 1, 2, 3, 4. First sample has all flags 0 and `locked`→1; the remaining four have `step_ok`=1.
- Locked at `bin_out`=0xFE (`grey_in` 0x81), then `grey_in` 0x80 then 0x00 → `bin_out` 0xFF with `step_ok`, then `bin_out` 0x00 with `step_ok`=1 and `wrap`=1.
- Locked at 3 (`grey_in` 0x02), repeat 0x02, then 0x05 (bin 6) → `hold`=1, then `step_err`=1 with `err_count`=1. Next sample 0x04 (bin 7) gives `step_ok`=1.
- Drive 300 alternating 0x00/0x03 samples → `step_err` on every locked sample and `err_count` saturates at 255.
- `resync` together with `in_valid` (0x07) while locked:
  - that sample is dropped;
  - `err_count`=0 and `locked`=0;
  - the next sample 0x06 produces `bin_out`=4 with all flags 0 and `locked`=1.
- Assert `rst` mid-stream with samples in both stages → all outputs 0 immediately, and no `out_valid` after `rst` deasserts until new input arrives.
